// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared MIPS definitions: FSM state codes, opcode/funct constants and ALU operation codes.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_ctr_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_multicycle_ctrl_funct_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported codes.
module mips_funct_dec
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_ctr_t   alu_code,
    output logic       legal
);

    always_comb begin
        alu_code = ALU_ADD;
        legal    = 1'b1;
        case (funct)
            FN_ADD:  alu_code = ALU_ADD;
            FN_SUB:  alu_code = ALU_SUB;
            FN_AND:  alu_code = ALU_AND;
            FN_OR:   alu_code = ALU_OR;
            FN_NOR:  alu_code = ALU_NOR;
            FN_SLT:  alu_code = ALU_SLT;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode and per-class execute/writeback steps.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctr,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t   state, next_state;
    alu_ctr_t rcode_q, dec_code;
    logic     is_bne_q;
    logic     funct_legal;

    mips_funct_dec u_funct_dec (
        .funct    (funct),
        .alu_code (dec_code),
        .legal    (funct_legal)
    );

    // NOTE: control registers reset asynchronously so every strobe (all decoded
    // from state) drops the moment rst_n falls, with no clock needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rcode_q  <= ALU_ADD;
            is_bne_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
            state <= next_state;
            if (state == S_DECODE) begin
                rcode_q  <= dec_code;
                is_bne_q <= (opcode == OP_BNE);
            end
        end
    end

    assign state_dbg = state;

    always_comb begin
        // NOTE: every output defaults first so no path through the case infers a latch.
        next_state = S_IDLE;
        pc_en      = 1'b0;
        pc_src     = PC_SRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_ctr    = ALU_AND;
        illegal_op = 1'b0;

        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                alu_ctr    = ALU_ADD;
                ir_write   = mem_ready;
                pc_en      = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH;
                alu_ctr   = ALU_ADD;
                case (opcode)
                    OP_RTYPE:      next_state = funct_legal ? S_EXEC : S_FETCH;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:       next_state = S_ADDIEX;
                    OP_J:          next_state = S_JUMP;
                    default:       next_state = S_FETCH;
                endcase
                illegal_op = (next_state == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_ctr    = ALU_ADD;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_ctr    = rcode_q;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctr    = ALU_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_en      = alu_zero ^ is_bne_q;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_ctr    = ALU_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PC_SRC_JUMP;
                pc_en      = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-cycle vector table through a scoreboard, plus hand-written reset sequences.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_ctr, state_dbg;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctr;
        logic       illegal_op;
        logic [3:0] st;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] opcode, funct;
        logic       zero, ready;
        out_t       exp;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected outputs per state, transcribed from the control table.
    function automatic out_t e_idle();
        return '0;
    endfunction
    function automatic out_t e_fetch(input logic rdy);
        out_t e = '0;
        e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_ctr = 4'd2;
        e.ir_write = rdy; e.pc_en = rdy; e.st = 4'd1;
        return e;
    endfunction
    function automatic out_t e_decode(input logic ill);
        out_t e = '0;
        e.alu_src_b = 2'b11; e.alu_ctr = 4'd2; e.illegal_op = ill; e.st = 4'd2;
        return e;
    endfunction
    function automatic out_t e_memadr();
        out_t e = '0;
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctr = 4'd2; e.st = 4'd3;
        return e;
    endfunction
    function automatic out_t e_memrd();
        out_t e = '0;
        e.mem_read = 1; e.iord = 1; e.st = 4'd4;
        return e;
    endfunction
    function automatic out_t e_memwb();
        out_t e = '0;
        e.mem_to_reg = 1; e.reg_write = 1; e.st = 4'd5;
        return e;
    endfunction
    function automatic out_t e_memwr();
        out_t e = '0;
        e.mem_write = 1; e.iord = 1; e.st = 4'd6;
        return e;
    endfunction
    function automatic out_t e_exec(input logic [3:0] code);
        out_t e = '0;
        e.alu_src_a = 1; e.alu_ctr = code; e.st = 4'd7;
        return e;
    endfunction
    function automatic out_t e_aluwb();
        out_t e = '0;
        e.reg_dst = 1; e.reg_write = 1; e.st = 4'd8;
        return e;
    endfunction
    function automatic out_t e_branch(input logic take);
        out_t e = '0;
        e.alu_src_a = 1; e.alu_ctr = 4'd6; e.pc_src = 2'b01; e.pc_en = take; e.st = 4'd9;
        return e;
    endfunction
    function automatic out_t e_addiex();
        out_t e = '0;
        e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctr = 4'd2; e.st = 4'd10;
        return e;
    endfunction
    function automatic out_t e_addiwb();
        out_t e = '0;
        e.reg_write = 1; e.st = 4'd11;
        return e;
    endfunction
    function automatic out_t e_jump();
        out_t e = '0;
        e.pc_src = 2'b10; e.pc_en = 1; e.st = 4'd12;
        return e;
    endfunction

    function automatic out_t actual();
        return {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_ctr, illegal_op, state_dbg};
    endfunction

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] f,
                       input logic z, input logic r, input out_t e);
        vecs.push_back('{n, op, f, z, r, e});
    endtask

    task automatic add_rtype(input logic [5:0] f, input logic [3:0] code);
        add("rt_fetch",  6'h00, f, 0, 1, e_fetch(1));
        add("rt_decode", 6'h00, f, 0, 1, e_decode(0));
        add("rt_exec",   6'h00, f, 0, 1, e_exec(code));
        add("rt_aluwb",  6'h00, f, 0, 1, e_aluwb());
    endtask

    task automatic add_branch(input logic [5:0] op, input logic z, input logic take);
        add("br_fetch",  op, 6'h00, z, 1, e_fetch(1));
        add("br_decode", op, 6'h00, z, 1, e_decode(0));
        add("br_branch", op, 6'h00, z, 1, e_branch(take));
    endtask

    task automatic add_illegal(input logic [5:0] op, input logic [5:0] f);
        add("ill_fetch",  op, f, 0, 1, e_fetch(1));
        add("ill_decode", op, f, 0, 1, e_decode(1));
    endtask

    // Scoreboard consumer: compares the oldest expectation away from the active edge.
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            sb_t s;
            s = sb.pop_front();
            check(s.name, 32'(actual()), 32'(s.exp));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;

        add("idle", 6'h00, 6'h22, 0, 1, e_idle());
        add_rtype(6'h22, 4'd6);
        add_rtype(6'h20, 4'd2);
        add_rtype(6'h24, 4'd0);
        add_rtype(6'h25, 4'd1);
        add_rtype(6'h27, 4'd12);
        add_rtype(6'h2A, 4'd7);
        add("lw_fetch_wait", 6'h23, 0, 0, 0, e_fetch(0));
        add("lw_fetch",      6'h23, 0, 0, 1, e_fetch(1));
        add("lw_decode",     6'h23, 0, 0, 1, e_decode(0));
        add("lw_memadr",     6'h23, 0, 0, 1, e_memadr());
        for (int i = 0; i < 3; i++) add("lw_memrd_wait", 6'h23, 0, 0, 0, e_memrd());
        add("lw_memrd",      6'h23, 0, 0, 1, e_memrd());
        add("lw_memwb",      6'h23, 0, 0, 1, e_memwb());
        add("sw_fetch",      6'h2B, 0, 0, 1, e_fetch(1));
        add("sw_decode",     6'h2B, 0, 0, 1, e_decode(0));
        add("sw_memadr",     6'h2B, 0, 0, 1, e_memadr());
        add("sw_memwr_wait", 6'h2B, 0, 0, 0, e_memwr());
        add("sw_memwr",      6'h2B, 0, 0, 1, e_memwr());
        add_branch(6'h04, 1, 1);
        add_branch(6'h04, 0, 0);
        add_branch(6'h05, 1, 0);
        add_branch(6'h05, 0, 1);
        add("addi_fetch",  6'h08, 0, 0, 1, e_fetch(1));
        add("addi_decode", 6'h08, 0, 0, 1, e_decode(0));
        add("addi_ex",     6'h08, 0, 0, 1, e_addiex());
        add("addi_wb",     6'h08, 0, 0, 1, e_addiwb());
        add("j_fetch",     6'h02, 0, 0, 1, e_fetch(1));
        add("j_decode",    6'h02, 0, 0, 1, e_decode(0));
        add("j_jump",      6'h02, 0, 0, 1, e_jump());
        add_illegal(6'h3F, 6'h20);
        add_illegal(6'h00, 6'h08);
        add("fetch_end",   6'h00, 6'h20, 0, 1, e_fetch(1));

        #12;
        check("reset_outputs", 32'(actual()), 32'(e_idle()));

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            opcode    = vecs[i].opcode;
            funct     = vecs[i].funct;
            alu_zero  = vecs[i].zero;
            mem_ready = vecs[i].ready;
            sb.push_back('{vecs[i].name, vecs[i].exp});
            @(negedge clk);
        end
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Async reset mid-stream, release, then a store stalled in MEMWR is cut by reset.
        @(negedge clk);
        rst_n = 1'b0; opcode = 6'h2B; funct = '0; mem_ready = 1'b1;
        #2;
        check("async_reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("release_idle", 32'(state_dbg), 32'd0);
        @(negedge clk);
        #2;
        check("first_fetch", 32'(state_dbg), 32'd1);
        @(negedge clk);
        #2;
        check("sw2_decode", 32'(state_dbg), 32'd2);
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        check("sw2_memadr", 32'(state_dbg), 32'd3);
        @(negedge clk);
        #2;
        check("sw2_memwr", 32'(actual()), 32'(e_memwr()));
        rst_n = 1'b0;
        #1;
        check("memwr_reset_mem_write", 32'(mem_write), 32'd0);
        check("memwr_reset_state", 32'(state_dbg), 32'd0);
        check("memwr_reset_all", 32'(actual()), 32'(e_idle()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
